// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle MSB-first magnitude comparator, D bits per cycle, unsigned or two's complement.
// Define CMP_EARLY_EXIT_EN to stop at the first differing chunk; otherwise every compare takes N chunks.
module seq_magnitude_comparator #(
  parameter int unsigned W = 16,
  parameter int unsigned D = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [W-1:0]            a,
  input  logic [W-1:0]            b,
  input  logic                    signed_mode,
  output logic                    ready,
  output logic                    done,
  output logic                    agtb,
  output logic                    aeqb,
  output logic                    altb,
  output logic [$clog2(W/D):0]    chunks_used
);

  localparam int unsigned N  = W / D;
  localparam int unsigned CW = $clog2(N) + 1;
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0] MSB_MASK = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;
  typedef enum logic [1:0] {R_NONE, R_GT, R_EQ, R_LT} res_t;

  state_t          state;
  logic [W-1:0]    a_r;
  logic [W-1:0]    b_r;
  logic [IW-1:0]   idx;
  logic [CW-1:0]   count;
  logic [D-1:0]    a_chunk;
  logic [D-1:0]    b_chunk;
  res_t            step_res;
  res_t            final_res;
  logic            finish;
`ifndef CMP_EARLY_EXIT_EN
  res_t            sticky;
  res_t            sticky_next;
`endif

  // Current chunk compare and decision whether this is the last CMP cycle
  always_comb begin
    a_chunk   = a_r[idx*D +: D];
    b_chunk   = b_r[idx*D +: D];
    step_res  = R_EQ;
    if (a_chunk > b_chunk)
      step_res = R_GT;
    else if (a_chunk < b_chunk)
      step_res = R_LT;
`ifdef CMP_EARLY_EXIT_EN
    finish    = (step_res != R_EQ) || (idx == '0);
    final_res = step_res;
`else
    sticky_next = sticky;
    if (sticky == R_NONE && step_res != R_EQ)
      sticky_next = step_res;
    finish    = (idx == '0);
    final_res = (sticky_next == R_NONE) ? R_EQ : sticky_next;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ready       <= 1'b1;
      done        <= 1'b0;
      agtb        <= 1'b0;
      aeqb        <= 1'b0;
      altb        <= 1'b0;
      chunks_used <= '0;
      a_r         <= '0;
      b_r         <= '0;
      idx         <= '0;
      count       <= '0;
`ifndef CMP_EARLY_EXIT_EN
      sticky      <= R_NONE;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // Offset-binary: flipping both sign bits turns a signed compare into an unsigned one
            a_r   <= signed_mode ? (a ^ MSB_MASK) : a;
            b_r   <= signed_mode ? (b ^ MSB_MASK) : b;
            idx   <= IW'(N - 1);
            count <= '0;
`ifndef CMP_EARLY_EXIT_EN
            sticky <= R_NONE;
`endif
            ready <= 1'b0;
            state <= CMP;
          end
        end
        CMP: begin
          count <= count + CW'(1);
`ifndef CMP_EARLY_EXIT_EN
          sticky <= sticky_next;
`endif
          if (finish) begin
            // Results become visible together with the done pulse
            done        <= 1'b1;
            agtb        <= (final_res == R_GT);
            aeqb        <= (final_res == R_EQ);
            altb        <= (final_res == R_LT);
            chunks_used <= count + CW'(1);
            state       <= DONE;
          end else begin
            idx <= idx - IW'(1);
          end
        end
        DONE: begin
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Self-checking bench for seq_magnitude_comparator: directed table, corner sequences, random vs. arithmetic model.
// Honors CMP_EARLY_EXIT_EN to pick the expected latency/chunk count.
module tb_seq_magnitude_comparator;

  localparam int unsigned W  = 16;
  localparam int unsigned D  = 2;
  localparam int unsigned N  = W / D;
  localparam int unsigned CW = $clog2(N) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          signed_mode;
  logic          ready;
  logic          done;
  logic          agtb;
  logic          aeqb;
  logic          altb;
  logic [CW-1:0] chunks_used;

  int vectors     = 0;
  int miscompares = 0;
  logic [2:0] prev_res = 3'b000;

  seq_magnitude_comparator #(.W(W), .D(D)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .signed_mode(signed_mode), .ready(ready), .done(done),
    .agtb(agtb), .aeqb(aeqb), .altb(altb), .chunks_used(chunks_used)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sm;
    logic [2:0]   res;   // {gt, eq, lt}
    int           k;     // chunks examined with early exit
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
    end
  endtask

  // Reference: compare as integers, chunk count from the highest differing bit
  function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic sm,
                                output logic [2:0] res, output int k);
    longint va, vb;
    logic [W-1:0] x;
    int hi;
    va = longint'(ma);
    vb = longint'(mb);
    if (sm && ma[W-1]) va = va - (longint'(1) << W);
    if (sm && mb[W-1]) vb = vb - (longint'(1) << W);
    res = {va > vb, va == vb, va < vb};
    x = ma ^ mb;
    hi = -1;
    for (int i = 0; i < int'(W); i++) if (x[i]) hi = i;
    k = (hi < 0) ? int'(N) : (int'(W) - 1 - hi) / int'(D) + 1;
  endfunction

  // Issue one compare from a negedge with ready=1; returns at the negedge after done
  task automatic run(input logic [W-1:0] ta, input logic [W-1:0] tb_b, input logic sm,
                     output logic [2:0] res, output int lat, output logic [CW-1:0] cu,
                     output bit busy_ok, output bit got_done, output logic rdy_after);
    a = ta; b = tb_b; signed_mode = sm; start = 1'b1;
    @(posedge clk);
    lat = 0; busy_ok = 1'b1; got_done = 1'b0; res = 3'b000; cu = '0; rdy_after = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = 1'b0;
      a = W'($urandom); b = W'($urandom); signed_mode = 1'($urandom);
      if (ready) busy_ok = 1'b0;
      if (done) begin
        lat = c; res = {agtb, aeqb, altb}; cu = chunks_used; got_done = 1'b1;
        break;
      end
      if ({agtb, aeqb, altb} !== prev_res) busy_ok = 1'b0;
    end
    @(negedge clk);
    rdy_after = ready;
  endtask

  task automatic run_check(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb_b,
                           input logic sm, input logic [2:0] exp_res, input int k);
    logic [2:0] res; int lat; logic [CW-1:0] cu; bit busy_ok, got_done; logic rdy;
    int exp_lat, exp_cu;
`ifdef CMP_EARLY_EXIT_EN
    exp_lat = k + 1; exp_cu = k;
`else
    exp_lat = int'(N) + 1; exp_cu = int'(N);
`endif
    run(ta, tb_b, sm, res, lat, cu, busy_ok, got_done, rdy);
    chk({nm, ".done_seen"}, 32'(got_done), 32'(1));
    chk({nm, ".result"},    32'(res), 32'(exp_res));
    chk({nm, ".latency"},   32'(lat), 32'(exp_lat));
    chk({nm, ".chunks"},    32'(cu), 32'(exp_cu));
    chk({nm, ".busy_hold"}, 32'(busy_ok), 32'(1));
    chk({nm, ".ready_after"}, 32'(rdy), 32'(1));
    prev_res = exp_res;
  endtask

  vec_t tbl [9];

  initial begin
    logic [2:0] mres; int mk;
    logic [W-1:0] ra, rb, one;
    logic rsm;
    int lat; bit seen;

    tbl[0] = '{16'h8000, 16'h7FFF, 1'b0, 3'b100, 1};
    tbl[1] = '{16'h1234, 16'h1234, 1'b0, 3'b010, 8};
    tbl[2] = '{16'hFFFF, 16'h0001, 1'b1, 3'b001, 1};
    tbl[3] = '{16'hFFFF, 16'h0001, 1'b0, 3'b100, 1};
    tbl[4] = '{16'h8000, 16'h7FFF, 1'b1, 3'b001, 1};
    tbl[5] = '{16'h0001, 16'h0000, 1'b0, 3'b100, 8};
    tbl[6] = '{16'h0000, 16'h0001, 1'b0, 3'b001, 8};
    tbl[7] = '{16'h1230, 16'h1238, 1'b0, 3'b001, 7};
    tbl[8] = '{16'hFFFF, 16'hFFFE, 1'b1, 3'b100, 8};

    reset = 1'b1; start = 1'b0; a = '0; b = '0; signed_mode = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset.ready", 32'(ready), 32'(1));
    chk("reset.done", 32'(done), 32'(0));
    chk("reset.result", 32'({agtb, aeqb, altb}), 32'(0));
    chk("reset.chunks", 32'(chunks_used), 32'(0));
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++)
      run_check($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].sm, tbl[i].res, tbl[i].k);

    // Start pulse while busy must be ignored
    a = 16'h0001; b = 16'h0000; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk);
    lat = 0; seen = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = (c == 2);
      if (c == 2) begin a = 16'h0000; b = 16'h0001; end
      if (done) begin
        lat = c; seen = 1'b1;
        chk("busy.result", 32'({agtb, aeqb, altb}), 32'(3'b100));
        break;
      end
    end
    start = 1'b0;
    chk("busy.done_seen", 32'(seen), 32'(1));
    chk("busy.latency", 32'(lat), 32'(N + 1));
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done || !ready) seen = 1'b1;
    end
    chk("busy.no_second_compare", 32'(seen), 32'(0));
    chk("busy.result_held", 32'({agtb, aeqb, altb}), 32'(3'b100));

    // Reset in the middle of a compare aborts it
    a = 16'h1234; b = 16'h1234; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid.done", 32'(done), 32'(0));
    chk("rst_mid.result", 32'({agtb, aeqb, altb}), 32'(0));
    chk("rst_mid.chunks", 32'(chunks_used), 32'(0));
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid.ready", 32'(ready), 32'(1));
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done || !ready || ({agtb, aeqb, altb} != 3'b000)) seen = 1'b1;
    end
    chk("rst_mid.quiet", 32'(seen), 32'(0));
    prev_res = 3'b000;

    // Random operands: full random, equal, single-bit difference
    one = 1;
    for (int i = 0; i < 150; i++) begin
      ra  = W'($urandom);
      rsm = 1'($urandom);
      case ($urandom_range(0, 2))
        0:       rb = W'($urandom);
        1:       rb = ra;
        default: rb = ra ^ (one << $urandom_range(0, W - 1));
      endcase
      model(ra, rb, rsm, mres, mk);
      run_check($sformatf("rnd%0d", i), ra, rb, rsm, mres, mk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
